wd_apb_master: RTL and testbench

- APB initiator that drives the watchdog register interface (StartValue, feed-dog, mode registers) from a simple valid/ready command port.
- Used by the bench-side host model and by any on-chip controller that must program or feed the watchdog.
- Converts one command into one APB transfer (SETUP then ACCESS).
- Captures read data one cycle after ACCESS, because the watchdog slave registers prdata on the ACCESS edge.

---
 rtl/wd_apb_pkg.sv | 21 ++
 rtl/wd_apb_master_if.sv | 56 +++++
 rtl/wd_apb_master.sv | 150 +++++++++++++++
 tb/tb_wd_apb_master.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wd_apb_pkg.sv
// Shared definitions for the watchdog APB initiator and the watchdog slave:
// FSM state encoding, watchdog register map and the timeout fill word.
package wd_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RDCAP,
    ST_GAP
  } state_e;

  // Watchdog register map; must stay in sync with the slave decoder.
  localparam logic [7:0] reg_StartValue = 8'h00;
  localparam logic [7:0] reg_feeddog    = 8'h04;
  localparam logic [7:0] reg_mode       = 8'h08;

  // Read data returned when an ACCESS wait times out.
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/wd_apb_master_if.sv
// Command port plus APB bus of the watchdog APB initiator.
// Optional macro WD_APB_MASTER_PREADY_EN adds pready (slave wait states)
// and ptimeout (wait-limit pulse).
interface wd_apb_master_if #(
  parameter int AW = 8,
  parameter int DW = 32
);

  // Command / response side
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  // APB side
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
`ifdef WD_APB_MASTER_PREADY_EN
  logic          pready;
  logic          ptimeout;
`endif

`ifdef WD_APB_MASTER_PREADY_EN
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata,
    output psel, penable, pwrite, paddr, pwdata, ptimeout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  psel, penable, pwrite, paddr, pwdata, ptimeout
  );
`else
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata,
    output cmd_ready, rsp_valid, rsp_rdata,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  psel, penable, pwrite, paddr, pwdata
  );
`endif

endinterface

// File: rtl/wd_apb_master.sv
// APB initiator for the watchdog register block. One accepted command
// becomes one SETUP + ACCESS transfer; reads return the slave's registered
// prdata in the RDCAP cycle that follows ACCESS.
// Optional macro WD_APB_MASTER_PREADY_EN: ACCESS waits for pready, with a
// 16-bit wait limit that abandons the transfer and pulses ptimeout.
module wd_apb_master
  import wd_apb_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int IDLE_GAP = 0   // 0..15
) (
  input  logic            pclk,
  input  logic            prst_,
  wd_apb_master_if.master bus
);

`ifdef WD_APB_MASTER_PREADY_EN
  localparam int CNT_W = 16;
`else
  localparam int CNT_W = 4;
`endif

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  state_e           r_state;
  logic             r_psel;
  logic             r_penable;
  logic             r_pwrite;
  logic [AW-1:0]    r_paddr;
  logic [DW-1:0]    r_pwdata;
  logic             r_rsp_valid;
  logic [DW-1:0]    r_rsp_rdata;
  logic [CNT_W-1:0] r_cnt;       // GAP length, or ACCESS wait cycles
`ifdef WD_APB_MASTER_PREADY_EN
  logic             r_ptimeout;
`endif

  state_e w_after_rsp;
  logic   w_access_done;

  assign w_after_rsp = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;

`ifdef WD_APB_MASTER_PREADY_EN
  assign w_access_done = bus.pready;
`else
  assign w_access_done = 1'b1;
`endif

  // Transfer sequencer: state, APB drive registers, response and counter.
  always_ff @(posedge pclk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // only takes effect on a pclk edge; it is not in the sensitivity list.
    if (!prst_) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_cnt       <= '0;
`ifdef WD_APB_MASTER_PREADY_EN
      r_ptimeout  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch sees
      // the pre-edge register values and these defaults are safely overridden.
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef WD_APB_MASTER_PREADY_EN
      r_ptimeout  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_access_done) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            if (r_pwrite) begin
              r_rsp_valid <= 1'b1;
              r_state     <= w_after_rsp;
            end else begin
              r_state <= ST_RDCAP;
            end
          end
`ifdef WD_APB_MASTER_PREADY_EN
          else if (r_cnt == 16'hFFFE) begin
            // 65535th wait cycle: give up on the slave.
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_cnt       <= '0;
            r_ptimeout  <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= DW'(TIMEOUT_FILL);
            r_state     <= w_after_rsp;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        ST_RDCAP: begin
          r_cnt   <= '0;
          r_state <= w_after_rsp;
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = prst_ && (r_state == ST_IDLE);
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;

  // The slave registered prdata on the ACCESS edge, so during RDCAP it is
  // already stable and is forwarded straight onto the response.
  assign bus.rsp_valid = r_rsp_valid || (r_state == ST_RDCAP);
  assign bus.rsp_rdata = (r_state == ST_RDCAP) ? bus.prdata : r_rsp_rdata;

`ifdef WD_APB_MASTER_PREADY_EN
  assign bus.ptimeout  = r_ptimeout;
`endif

endmodule

// File: tb/tb_wd_apb_master.sv
// Directed bench for wd_apb_master: an IDLE_GAP=0 instance with a small
// watchdog register model as APB slave, and an IDLE_GAP=3 instance.
// Control vectors are {psel, penable, pwrite, rsp_valid, cmd_ready}.
module tb_wd_apb_master;
  import wd_apb_pkg::*;

  logic pclk;
  logic prst_;

  int n_cmp = 0;
  int n_mis = 0;

  wd_apb_master_if #(.AW(8), .DW(32)) bus0 ();
  wd_apb_master_if #(.AW(8), .DW(32)) bus3 ();

  wd_apb_master #(.AW(8), .DW(32), .IDLE_GAP(0)) u_dut0 (
    .pclk  (pclk),
    .prst_ (prst_),
    .bus   (bus0.master)
  );

  wd_apb_master #(.AW(8), .DW(32), .IDLE_GAP(3)) u_dut3 (
    .pclk  (pclk),
    .prst_ (prst_),
    .bus   (bus3.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic [4:0] w_ctl0;
  logic [4:0] w_ctl3;
  assign w_ctl0 = {bus0.psel, bus0.penable, bus0.pwrite, bus0.rsp_valid, bus0.cmd_ready};
  assign w_ctl3 = {bus3.psel, bus3.penable, bus3.pwrite, bus3.rsp_valid, bus3.cmd_ready};

  // Watchdog register model behind bus0: writes and read capture happen on
  // the ACCESS edge; mode resets to 2.
  logic [31:0] s_start;
  logic [1:0]  s_mode;
  int          s_feed_cnt;
  int          s_start_wr;
  logic        w_acc0;

`ifdef WD_APB_MASTER_PREADY_EN
  assign w_acc0 = bus0.psel && bus0.penable && bus0.pready;
`else
  assign w_acc0 = bus0.psel && bus0.penable;
`endif

  // Slave register updates and registered read data.
  always @(posedge pclk) begin
    if (!prst_) begin
      s_start     <= '0;
      s_mode      <= 2'b10;
      s_feed_cnt  <= 0;
      s_start_wr  <= 0;
      bus0.prdata <= '0;
    end else if (w_acc0) begin
      if (bus0.pwrite) begin
        case (bus0.paddr)
          reg_StartValue: begin
            s_start    <= bus0.pwdata;
            s_start_wr <= s_start_wr + 1;
          end
          reg_feeddog: s_feed_cnt <= s_feed_cnt + 1;
          reg_mode:    s_mode     <= bus0.pwdata[1:0];
          default:     ;
        endcase
      end else begin
        case (bus0.paddr)
          reg_StartValue: bus0.prdata <= s_start;
          reg_mode:       bus0.prdata <= {30'b0, s_mode};
          default:        bus0.prdata <= '0;
        endcase
      end
    end
  end

  task automatic drive0(input logic v, input logic w, input logic [7:0] a, input logic [31:0] d);
    bus0.cmd_valid = v;
    bus0.cmd_write = w;
    bus0.cmd_addr  = a;
    bus0.cmd_wdata = d;
  endtask

  task automatic drive3(input logic v, input logic w, input logic [7:0] a, input logic [31:0] d);
    bus3.cmd_valid = v;
    bus3.cmd_write = w;
    bus3.cmd_addr  = a;
    bus3.cmd_wdata = d;
  endtask

  task automatic test_reset();
    prst_ = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    n_cmp++;
    if (w_ctl0 !== 5'b00000) begin
      n_mis++; $display("FAIL reset_ctl0: got %b want %b", w_ctl0, 5'b00000);
    end
    n_cmp++;
    if ({bus0.paddr, bus0.pwdata, bus0.rsp_rdata} !== 72'h0) begin
      n_mis++; $display("FAIL reset_regs0: got %h/%h/%h want 0", bus0.paddr, bus0.pwdata, bus0.rsp_rdata);
    end
    n_cmp++;
    if (w_ctl3 !== 5'b00000) begin
      n_mis++; $display("FAIL reset_ctl3: got %b want %b", w_ctl3, 5'b00000);
    end
    prst_ = 1'b1;
    @(negedge pclk);
    n_cmp++;
    if (w_ctl0 !== 5'b00001) begin
      n_mis++; $display("FAIL release_ctl0: got %b want %b", w_ctl0, 5'b00001);
    end
    n_cmp++;
    if (w_ctl3 !== 5'b00001) begin
      n_mis++; $display("FAIL release_ctl3: got %b want %b", w_ctl3, 5'b00001);
    end
  endtask

  task automatic test_read_mode_reset();
    logic [4:0] exp_ctl [4];
    exp_ctl = '{5'b10000, 5'b11000, 5'b00010, 5'b00001};
    // Nonzero wdata on a read must not reach pwdata.
    drive0(1'b1, 1'b0, reg_mode, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      if (i == 0) bus0.cmd_valid = 1'b0;
      @(negedge pclk);
      n_cmp++;
      if (w_ctl0 !== exp_ctl[i]) begin
        n_mis++; $display("FAIL rd_mode_ctl c%0d: got %b want %b", i + 1, w_ctl0, exp_ctl[i]);
      end
      if (i == 0) begin
        n_cmp++;
        if ({bus0.paddr, bus0.pwdata} !== {reg_mode, 32'h0}) begin
          n_mis++; $display("FAIL rd_mode_addr: got %h/%h want %h/0", bus0.paddr, bus0.pwdata, reg_mode);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (bus0.rsp_rdata !== 32'h2) begin
          n_mis++; $display("FAIL rd_mode_data: got %h want %h", bus0.rsp_rdata, 32'h2);
        end
      end
    end
  endtask

  task automatic test_write_start();
    logic [4:0] exp_ctl [4];
    exp_ctl = '{5'b10100, 5'b11100, 5'b00111, 5'b00101};
    drive0(1'b1, 1'b1, reg_StartValue, 32'h0000_1234);
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      if (i == 0) bus0.cmd_valid = 1'b0;
      @(negedge pclk);
      n_cmp++;
      if (w_ctl0 !== exp_ctl[i]) begin
        n_mis++; $display("FAIL wr_start_ctl c%0d: got %b want %b", i + 1, w_ctl0, exp_ctl[i]);
      end
      if (i < 2) begin
        n_cmp++;
        if ({bus0.paddr, bus0.pwdata} !== {reg_StartValue, 32'h0000_1234}) begin
          n_mis++; $display("FAIL wr_start_bus c%0d: got %h/%h want %h/1234", i + 1, bus0.paddr, bus0.pwdata, reg_StartValue);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (bus0.rsp_rdata !== 32'h0) begin
          n_mis++; $display("FAIL wr_start_rdata: got %h want 0", bus0.rsp_rdata);
        end
        n_cmp++;
        if (s_start !== 32'h0000_1234 || s_start_wr != 1) begin
          n_mis++; $display("FAIL wr_start_slave: got %h x%0d want 1234 x1", s_start, s_start_wr);
        end
      end
    end
  endtask

  task automatic test_mode_rw();
    logic [4:0] exp_ctl [8];
    exp_ctl = '{5'b10100, 5'b11100, 5'b00111, 5'b00101,
                5'b10000, 5'b11000, 5'b00010, 5'b00001};
    drive0(1'b1, 1'b1, reg_mode, 32'h0000_0001);
    for (int i = 0; i < 8; i++) begin
      @(posedge pclk); #1;
      if (i == 0 || i == 4) bus0.cmd_valid = 1'b0;
      @(negedge pclk);
      n_cmp++;
      if (w_ctl0 !== exp_ctl[i]) begin
        n_mis++; $display("FAIL mode_rw_ctl c%0d: got %b want %b", i + 1, w_ctl0, exp_ctl[i]);
      end
      if (i == 3) drive0(1'b1, 1'b0, reg_mode, 32'h0);
      if (i == 6) begin
        n_cmp++;
        if (bus0.rsp_rdata !== 32'h1) begin
          n_mis++; $display("FAIL mode_rw_data: got %h want %h", bus0.rsp_rdata, 32'h1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_ctl [7];
    exp_ctl = '{5'b10100, 5'b11100, 5'b00111, 5'b10000, 5'b11000, 5'b00010, 5'b00001};
    drive0(1'b1, 1'b1, reg_StartValue, 32'h0000_0005);
    for (int i = 0; i < 7; i++) begin
      @(posedge pclk); #1;
      if (i == 0) drive0(1'b1, 1'b0, reg_StartValue, 32'h0);
      if (i == 3) bus0.cmd_valid = 1'b0;
      @(negedge pclk);
      n_cmp++;
      if (w_ctl0 !== exp_ctl[i]) begin
        n_mis++; $display("FAIL b2b_ctl c%0d: got %b want %b", i + 1, w_ctl0, exp_ctl[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (bus0.pwdata !== 32'h5) begin
          n_mis++; $display("FAIL b2b_wdata: got %h want 5", bus0.pwdata);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if ({bus0.paddr, bus0.pwdata} !== {reg_StartValue, 32'h0}) begin
          n_mis++; $display("FAIL b2b_rd_bus: got %h/%h want %h/0", bus0.paddr, bus0.pwdata, reg_StartValue);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (bus0.rsp_rdata !== 32'h5) begin
          n_mis++; $display("FAIL b2b_rdata: got %h want 5", bus0.rsp_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp_ctl [8];
    exp_ctl = '{5'b10100, 5'b11100, 5'b00000, 5'b00000,
                5'b10100, 5'b11100, 5'b00111, 5'b00101};
    drive0(1'b1, 1'b1, reg_feeddog, 32'h0000_00AA);
    for (int i = 0; i < 8; i++) begin
      @(posedge pclk); #1;
      if (i == 0 || i == 4) bus0.cmd_valid = 1'b0;
      @(negedge pclk);
      n_cmp++;
      if (w_ctl0 !== exp_ctl[i]) begin
        n_mis++; $display("FAIL rst_mid_ctl c%0d: got %b want %b", i + 1, w_ctl0, exp_ctl[i]);
      end
      if (i == 1) prst_ = 1'b0;
      if (i == 3) begin
        prst_ = 1'b1;
        drive0(1'b1, 1'b1, reg_feeddog, 32'h0000_0055);
      end
      if (i == 6) begin
        n_cmp++;
        if (s_feed_cnt != 1 || bus0.rsp_rdata !== 32'h0) begin
          n_mis++; $display("FAIL rst_mid_feed: got cnt %0d rdata %h want 1/0", s_feed_cnt, bus0.rsp_rdata);
        end
      end
    end
  endtask

  task automatic test_idle_gap();
    logic [4:0] exp_ctl [9];
    int         n_low;
    exp_ctl = '{5'b10100, 5'b11100, 5'b00110, 5'b00100, 5'b00100,
                5'b00101, 5'b10100, 5'b11100, 5'b00110};
    n_low = 0;
    drive3(1'b1, 1'b1, reg_StartValue, 32'h0000_0011);
    for (int i = 0; i < 9; i++) begin
      @(posedge pclk); #1;
      if (i == 0) drive3(1'b1, 1'b1, reg_feeddog, 32'h0000_0022);
      if (i == 6) bus3.cmd_valid = 1'b0;
      @(negedge pclk);
      n_cmp++;
      if (w_ctl3 !== exp_ctl[i]) begin
        n_mis++; $display("FAIL gap_ctl c%0d: got %b want %b", i + 1, w_ctl3, exp_ctl[i]);
      end
      if (i < 8 && !bus3.psel) n_low++;
      if (i == 6) begin
        n_cmp++;
        if ({bus3.paddr, bus3.pwdata} !== {reg_feeddog, 32'h0000_0022}) begin
          n_mis++; $display("FAIL gap_bus2: got %h/%h want %h/22", bus3.paddr, bus3.pwdata, reg_feeddog);
        end
      end
    end
    n_cmp++;
    if (n_low != 4) begin
      n_mis++; $display("FAIL gap_psel_low: got %0d want 4", n_low);
    end
  endtask

`ifdef WD_APB_MASTER_PREADY_EN
  task automatic test_pready();
    logic [4:0] exp_ctl [8];
    exp_ctl = '{5'b10100, 5'b11100, 5'b11100, 5'b11100,
                5'b11100, 5'b11100, 5'b11100, 5'b00111};
    bus0.pready = 1'b0;
    drive0(1'b1, 1'b1, reg_StartValue, 32'h0000_0077);
    for (int i = 0; i < 8; i++) begin
      @(posedge pclk); #1;
      if (i == 0) bus0.cmd_valid = 1'b0;
      if (i == 6) bus0.pready = 1'b1;
      @(negedge pclk);
      n_cmp++;
      if (w_ctl0 !== exp_ctl[i]) begin
        n_mis++; $display("FAIL pready_ctl c%0d: got %b want %b", i + 1, w_ctl0, exp_ctl[i]);
      end
      if (i >= 1 && i <= 6) begin
        n_cmp++;
        if ({bus0.paddr, bus0.pwdata} !== {reg_StartValue, 32'h0000_0077}) begin
          n_mis++; $display("FAIL pready_bus c%0d: got %h/%h want %h/77", i + 1, bus0.paddr, bus0.pwdata, reg_StartValue);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (bus0.ptimeout !== 1'b0 || bus0.rsp_rdata !== 32'h0 || s_start !== 32'h77) begin
          n_mis++; $display("FAIL pready_done: got to=%b rdata=%h slave=%h want 0/0/77", bus0.ptimeout, bus0.rsp_rdata, s_start);
        end
      end
    end
  endtask
`endif

  initial begin
    prst_ = 1'b0;
    drive0(1'b0, 1'b0, '0, '0);
    drive3(1'b0, 1'b0, '0, '0);
    bus3.prdata = '0;
`ifdef WD_APB_MASTER_PREADY_EN
    bus0.pready = 1'b1;
    bus3.pready = 1'b1;
`endif
    test_reset();
    test_read_mode_reset();
    test_write_start();
    test_mode_rw();
    test_back_to_back();
    test_reset_mid();
    test_idle_gap();
`ifdef WD_APB_MASTER_PREADY_EN
    test_pready();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
